// File: rtl/kronos_types.sv
// Shared types for the Kronos pipeline: the EX->WB record and the WB state set.
package kronos_types;

   // Record handed from EX to WB. result1 is the architectural result,
   // result2 carries the faulting value (instruction word / address) for traps.
   typedef struct packed {
      logic [31:0] result1;
      logic [31:0] result2;
      logic [4:0]  rd;
      logic        rd_write;
      logic        illegal;
   } pipeEXWB_t;

   // Write-back control states.
   typedef enum logic [0:0] {
      WB_RUN  = 1'b0,
      WB_TRAP = 1'b1
   } wb_state_e;

endpackage

// File: rtl/kronos_counter.sv
// Free-running wrapping incrementer with enable; rolls over modulo 2^W.
module kronos_counter #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_d;
   logic [W-1:0] count_q;

   // Next count: +1 when enabled, natural overflow gives the wrap.
   always_comb begin
      count_d = count_q;
      if (en) count_d = count_q + {{(W-1){1'b0}}, 1'b1};
   end

   // Count register, cleared immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/kronos_wb.sv
// Kronos write-back stage: commits EX results, forwards them, counts
// retirements and parks the pipe on an illegal instruction until acknowledged.
module kronos_wb
   import kronos_types::*;
#(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  pipeEXWB_t        execute,
   input  logic             pipe_in_vld,
   output logic             pipe_in_rdy,
   output logic             regwr_en,
   output logic [4:0]       regwr_sel,
   output logic [31:0]      regwr_data,
   output logic             fwd_vld,
   output logic [4:0]       fwd_rd,
   output logic [31:0]      fwd_data,
   output logic             trap_vld,
   output logic [31:0]      trap_value,
   input  logic             trap_ack,
   output logic [CNT_W-1:0] instret
);

   wb_state_e   state_d, state_q;
   logic        regwr_en_d, regwr_en_q;
   logic [4:0]  regwr_sel_d, regwr_sel_q;
   logic [31:0] regwr_data_d, regwr_data_q;
   logic [31:0] trap_value_d, trap_value_q;
   logic        accept;
   logic        retire;

   // Ready depends only on state, so EX never sees a loop through pipe_in_vld.
   assign pipe_in_rdy = (state_q == WB_RUN);
   assign accept      = pipe_in_vld & pipe_in_rdy;
   assign retire      = accept & ~execute.illegal;

   // Next-state, commit and trap-capture decisions.
   always_comb begin
      state_d      = state_q;
      regwr_en_d   = 1'b0;
      regwr_sel_d  = regwr_sel_q;
      regwr_data_d = regwr_data_q;
      trap_value_d = trap_value_q;

      case (state_q)
         WB_RUN: begin
            if (accept) begin
               if (execute.illegal) begin
                  trap_value_d = execute.result2;
                  state_d      = WB_TRAP;
               end else if (execute.rd_write && (execute.rd != 5'd0)) begin
                  // x0 is hardwired to zero, so writes to it are dropped here.
                  regwr_en_d   = 1'b1;
                  regwr_sel_d  = execute.rd;
                  regwr_data_d = execute.result1;
               end
            end
         end
         WB_TRAP: begin
            if (trap_ack) state_d = WB_RUN;
         end
         default: state_d = WB_RUN;
      endcase
   end

   // State and output registers; reset discards any pending trap at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= WB_RUN;
         regwr_en_q   <= 1'b0;
         regwr_sel_q  <= 5'd0;
         regwr_data_q <= 32'd0;
         trap_value_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         regwr_en_q   <= regwr_en_d;
         regwr_sel_q  <= regwr_sel_d;
         regwr_data_q <= regwr_data_d;
         trap_value_q <= trap_value_d;
      end
   end

   // Forwarding bus is the register-file write port seen by EX.
   assign regwr_en   = regwr_en_q;
   assign regwr_sel  = regwr_sel_q;
   assign regwr_data = regwr_data_q;
   assign fwd_vld    = regwr_en_q;
   assign fwd_rd     = regwr_sel_q;
   assign fwd_data   = regwr_data_q;
   assign trap_vld   = (state_q == WB_TRAP);
   assign trap_value = trap_value_q;

   kronos_counter #(.W(CNT_W)) u_instret (
      .clk   (clk),
      .rst   (rst),
      .en    (retire),
      .count (instret)
   );

endmodule

// File: tb/tb_kronos_wb.sv
// Self-checking bench for kronos_wb: directed scenarios plus random traffic
// against a transaction-level model (trap flag, retire count, write queue).
module tb_kronos_wb;
   import kronos_types::*;

   logic        clk = 1'b0;
   logic        rst;
   pipeEXWB_t   execute;
   logic        pipe_in_vld;
   logic        pipe_in_rdy, pipe_in_rdy4;
   logic        regwr_en, regwr_en4;
   logic [4:0]  regwr_sel, regwr_sel4;
   logic [31:0] regwr_data, regwr_data4;
   logic        fwd_vld, fwd_vld4;
   logic [4:0]  fwd_rd, fwd_rd4;
   logic [31:0] fwd_data, fwd_data4;
   logic        trap_vld, trap_vld4;
   logic [31:0] trap_value, trap_value4;
   logic        trap_ack;
   logic [63:0] instret;
   logic [3:0]  instret4;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit          m_trap;
   bit [31:0]   m_tval;
   longint unsigned m_cnt;
   bit          m_wr;
   bit [36:0]   sb[$];

   always #5 clk = ~clk;

   kronos_wb #(.CNT_W(64)) dut (
      .clk(clk), .rst(rst), .execute(execute), .pipe_in_vld(pipe_in_vld),
      .pipe_in_rdy(pipe_in_rdy), .regwr_en(regwr_en), .regwr_sel(regwr_sel),
      .regwr_data(regwr_data), .fwd_vld(fwd_vld), .fwd_rd(fwd_rd),
      .fwd_data(fwd_data), .trap_vld(trap_vld), .trap_value(trap_value),
      .trap_ack(trap_ack), .instret(instret)
   );

   kronos_wb #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .execute(execute), .pipe_in_vld(pipe_in_vld),
      .pipe_in_rdy(pipe_in_rdy4), .regwr_en(regwr_en4), .regwr_sel(regwr_sel4),
      .regwr_data(regwr_data4), .fwd_vld(fwd_vld4), .fwd_rd(fwd_rd4),
      .fwd_data(fwd_data4), .trap_vld(trap_vld4), .trap_value(trap_value4),
      .trap_ack(trap_ack), .instret(instret4)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_trap = 1'b0;
      m_tval = 32'd0;
      m_cnt  = 0;
      m_wr   = 1'b0;
      sb.delete();
   endtask

   task automatic drive(input bit vld, input bit [31:0] r1, input bit [31:0] r2,
                        input bit [4:0] rd, input bit wr, input bit ill);
      pipe_in_vld      = vld;
      execute.result1  = r1;
      execute.result2  = r2;
      execute.rd       = rd;
      execute.rd_write = wr;
      execute.illegal  = ill;
   endtask

   task automatic drive_rand_legal();
      drive(1'b1, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
   endtask

   // One clock: apply model rules to the inputs present at the edge, then compare.
   task automatic cycle();
      bit        acc;
      bit [36:0] exp_w;
      acc = pipe_in_vld && !m_trap;
      @(posedge clk);
      #1;
      m_wr = acc && !execute.illegal && execute.rd_write && (execute.rd != 5'd0);
      if (m_wr) sb.push_back({execute.rd, execute.result1});
      if (acc && !execute.illegal) m_cnt++;
      if (acc && execute.illegal) begin
         m_trap = 1'b1;
         m_tval = execute.result2;
      end else if (m_trap && trap_ack) begin
         m_trap = 1'b0;
      end
      check_eq("regwr_en", regwr_en, m_wr);
      check_eq("fwd_vld", fwd_vld, m_wr);
      if (regwr_en && sb.size() > 0) begin
         exp_w = sb.pop_front();
         check_eq("regwr_sel", regwr_sel, exp_w[36:32]);
         check_eq("regwr_data", regwr_data, exp_w[31:0]);
         check_eq("fwd_rd", fwd_rd, exp_w[36:32]);
         check_eq("fwd_data", fwd_data, exp_w[31:0]);
      end
      check_eq("pipe_in_rdy", pipe_in_rdy, !m_trap);
      check_eq("trap_vld", trap_vld, m_trap);
      if (m_trap) check_eq("trap_value", trap_value, m_tval);
      check_eq("instret", instret, m_cnt);
      check_eq("instret4", instret4, m_cnt % 16);
   endtask

   task automatic check_all_reset(input string tag);
      check_eq({tag, "_regwr_en"}, regwr_en, 0);
      check_eq({tag, "_regwr_sel"}, regwr_sel, 0);
      check_eq({tag, "_regwr_data"}, regwr_data, 0);
      check_eq({tag, "_fwd_vld"}, fwd_vld, 0);
      check_eq({tag, "_fwd_rd"}, fwd_rd, 0);
      check_eq({tag, "_fwd_data"}, fwd_data, 0);
      check_eq({tag, "_trap_vld"}, trap_vld, 0);
      check_eq({tag, "_trap_value"}, trap_value, 0);
      check_eq({tag, "_instret"}, instret, 0);
      check_eq({tag, "_instret4"}, instret4, 0);
   endtask

   task automatic reset_release();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      trap_ack = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_reset("reset");
      rst = 1'b0;
      cycle();

      // ADD write to x5
      drive(1'b1, 32'h0000_0007, 32'h0, 5'd5, 1'b1, 1'b0);
      cycle();
      drive(1'b0, 0, 0, 0, 0, 0);
      check_eq("add_regwr_en", regwr_en, 1);
      check_eq("add_regwr_sel", regwr_sel, 5);
      check_eq("add_regwr_data", regwr_data, 7);
      check_eq("add_fwd_rd", fwd_rd, 5);
      check_eq("add_instret", instret, 1);
      cycle();

      // x0 write and rd_write=0: both retire, neither writes
      drive(1'b1, 32'h1111_1111, 32'h0, 5'd0, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 32'h2222_2222, 32'h0, 5'd3, 1'b0, 1'b0);
      cycle();
      drive(1'b0, 0, 0, 0, 0, 0);
      cycle();
      check_eq("x0_instret", instret, 3);

      // Illegal instruction, then a legal record held against the stall
      drive(1'b1, 32'h0, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b1);
      cycle();
      check_eq("trap_vld_set", trap_vld, 1);
      check_eq("trap_value_cap", trap_value, 32'hDEAD_BEEF);
      check_eq("trap_rdy_low", pipe_in_rdy, 0);
      drive(1'b1, 32'hCAFE_F00D, 32'h0, 5'd12, 1'b1, 1'b0);
      repeat (5) cycle();
      check_eq("trap_hold_instret", instret, 3);
      trap_ack = 1'b1;
      cycle();
      trap_ack = 1'b0;
      check_eq("ack_rdy", pipe_in_rdy, 1);
      check_eq("ack_trap_clr", trap_vld, 0);
      cycle();
      drive(1'b0, 0, 0, 0, 0, 0);
      check_eq("post_ack_commit_en", regwr_en, 1);
      check_eq("post_ack_commit_data", regwr_data, 32'hCAFE_F00D);
      cycle();

      // Reset while a trap is pending
      drive(1'b1, 32'h0, 32'h1234_5678, 5'd1, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 0, 0, 0, 0, 0);
      cycle();
      check_eq("pre_rst_trap_vld", trap_vld, 1);
      #3;
      rst = 1'b1;
      #1;
      check_all_reset("async_rst");
      check_eq("async_rst_rdy", pipe_in_rdy, 1);
      reset_release();
      cycle();
      check_eq("post_rst_instret", instret, 0);

      // Streaming: 128 back-to-back random legal records
      for (int i = 0; i < 128; i++) begin
         drive_rand_legal();
         cycle();
      end
      drive(1'b0, 0, 0, 0, 0, 0);
      cycle();
      check_eq("stream_instret", instret, 128);
      check_eq("stream_sb_drained", sb.size(), 0);

      // Wrap of a 4-bit counter after 17 retirements
      rst = 1'b1;
      reset_release();
      for (int i = 0; i < 17; i++) begin
         drive_rand_legal();
         cycle();
      end
      drive(1'b0, 0, 0, 0, 0, 0);
      cycle();
      check_eq("wrap_instret4", instret4, 1);
      check_eq("wrap_instret64", instret, 17);

      // Random mix of bubbles, illegal records and acks (acks in RUN are ignored)
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0)
            drive(1'b1, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
         else if ($urandom_range(0, 4) == 0)
            drive(1'b0, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         else
            drive_rand_legal();
         trap_ack = ($urandom_range(0, 3) == 0);
         cycle();
      end
      trap_ack = 1'b0;
      drive(1'b0, 0, 0, 0, 0, 0);
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
